// File: rtl/multichannel_comparator_if.sv
// AXI-stream style sample bus: data plus a dest field used as the channel index.
// The slave drives ready; the comparator ties it high.
interface axi_stream #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEST_WIDTH = 8
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [DEST_WIDTH-1:0] dest;

  modport master (output valid, output data, output dest, input ready);
  modport slave  (input valid, input data, input dest, output ready);
endinterface

// File: rtl/multichannel_comparator.sv
// Multi-channel hysteresis window comparator with per-channel debounce, trip latching
// and first-fault capture. Only the channel addressed by the accepted sample updates.
module multichannel_comparator #(
  parameter int unsigned DATA_PATH_WIDTH = 16,
  parameter int unsigned N_CHANNELS      = 4,
  parameter int unsigned DEBOUNCE_WIDTH  = 8,
  localparam int unsigned CH_W           = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic signed [DATA_PATH_WIDTH-1:0] thresholds [0:N_CHANNELS-1][0:3],
  axi_stream.slave                          data_in,
  input  logic [DEBOUNCE_WIDTH-1:0]         debounce_length,
  input  logic                              latching_mode,
  input  logic [N_CHANNELS-1:0]             clear_latch,
  input  logic                              clear_first_fault,
  output logic [N_CHANNELS-1:0]             trip_high,
  output logic [N_CHANNELS-1:0]             trip_low,
  output logic                              trip_any,
  output logic                              first_fault_valid,
  output logic [CH_W-1:0]                   first_fault_channel,
  output logic                              first_fault_high
);

  logic [N_CHANNELS-1:0]     trip_high_q, trip_high_d;
  logic [N_CHANNELS-1:0]     trip_low_q, trip_low_d;
  logic [N_CHANNELS-1:0]     latched_q, latched_d;
  logic [DEBOUNCE_WIDTH-1:0] cnt_hi_q [N_CHANNELS];
  logic [DEBOUNCE_WIDTH-1:0] cnt_hi_d [N_CHANNELS];
  logic [DEBOUNCE_WIDTH-1:0] cnt_lo_q [N_CHANNELS];
  logic [DEBOUNCE_WIDTH-1:0] cnt_lo_d [N_CHANNELS];
  logic                      ff_valid_q, ff_valid_d;
  logic [CH_W-1:0]           ff_ch_q, ff_ch_d;
  logic                      ff_high_q, ff_high_d;

  logic signed [DATA_PATH_WIDTH-1:0] sample;
  logic [31:0]                       dest_ext;
  logic [CH_W-1:0]                   ch;
  logic                              accept;
  logic                              hold;
  logic                              set_hi, set_lo;
  logic [DEBOUNCE_WIDTH-1:0]         deb_len;
  logic [DEBOUNCE_WIDTH-1:0]         cnt_hi_inc, cnt_lo_inc;

  assign data_in.ready = 1'b1;

  always_comb begin
    trip_high_d = trip_high_q;
    trip_low_d  = trip_low_q;
    latched_d   = latched_q;
    cnt_hi_d    = cnt_hi_q;
    cnt_lo_d    = cnt_lo_q;
    ff_valid_d  = ff_valid_q;
    ff_ch_d     = ff_ch_q;
    ff_high_d   = ff_high_q;
    set_hi      = 1'b0;
    set_lo      = 1'b0;
    hold        = 1'b0;
    cnt_hi_inc  = '0;
    cnt_lo_inc  = '0;
    sample      = $signed(data_in.data);
    dest_ext    = 32'(data_in.dest);
    ch          = dest_ext[CH_W-1:0];
    accept      = data_in.valid && (dest_ext < N_CHANNELS);
    deb_len     = (debounce_length == '0) ? DEBOUNCE_WIDTH'(1) : debounce_length;

    if (latching_mode) begin
      for (int i = 0; i < int'(N_CHANNELS); i++) begin
        if (clear_latch[i]) begin
          latched_d[i]   = 1'b0;
          trip_high_d[i] = 1'b0;
          trip_low_d[i]  = 1'b0;
        end
      end
    end else begin
      latched_d = '0;
    end

    if (accept) begin
      // Holding is judged on the pre-edge latch state; a coincident clear already zeroed trips.
      hold = latched_q[ch] & latching_mode;

      cnt_hi_inc = (&cnt_hi_q[ch]) ? cnt_hi_q[ch] : cnt_hi_q[ch] + 1'b1;
      cnt_lo_inc = (&cnt_lo_q[ch]) ? cnt_lo_q[ch] : cnt_lo_q[ch] + 1'b1;

      if (sample > thresholds[ch][3]) begin
        cnt_hi_d[ch] = cnt_hi_inc;
        set_hi       = (cnt_hi_inc >= deb_len);
      end else begin
        cnt_hi_d[ch] = '0;
      end

      if (sample < thresholds[ch][0]) begin
        cnt_lo_d[ch] = cnt_lo_inc;
        set_lo       = (cnt_lo_inc >= deb_len);
      end else begin
        cnt_lo_d[ch] = '0;
      end

      if ((sample < thresholds[ch][2]) && !hold) trip_high_d[ch] = 1'b0;
      if ((sample > thresholds[ch][1]) && !hold) trip_low_d[ch]  = 1'b0;

      // A set on this edge wins over a coincident latch clear.
      if (set_hi) begin
        trip_high_d[ch] = 1'b1;
        latched_d[ch]   = latching_mode;
      end
      if (set_lo) begin
        trip_low_d[ch] = 1'b1;
        latched_d[ch]  = latching_mode;
      end
    end

    if (clear_first_fault) begin
      ff_valid_d = 1'b0;
      ff_ch_d    = '0;
      ff_high_d  = 1'b0;
    end
    if ((set_hi || set_lo) && (!ff_valid_q || clear_first_fault)) begin
      ff_valid_d = 1'b1;
      ff_ch_d    = ch;
      ff_high_d  = set_hi;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      trip_high_q <= '0;
      trip_low_q  <= '0;
      latched_q   <= '0;
      for (int i = 0; i < int'(N_CHANNELS); i++) begin
        cnt_hi_q[i] <= '0;
        cnt_lo_q[i] <= '0;
      end
      ff_valid_q  <= 1'b0;
      ff_ch_q     <= '0;
      ff_high_q   <= 1'b0;
    end else begin
      trip_high_q <= trip_high_d;
      trip_low_q  <= trip_low_d;
      latched_q   <= latched_d;
      cnt_hi_q    <= cnt_hi_d;
      cnt_lo_q    <= cnt_lo_d;
      ff_valid_q  <= ff_valid_d;
      ff_ch_q     <= ff_ch_d;
      ff_high_q   <= ff_high_d;
    end
  end

  assign trip_high           = trip_high_q;
  assign trip_low            = trip_low_q;
  assign trip_any            = (|trip_high_q) | (|trip_low_q);
  assign first_fault_valid   = ff_valid_q;
  assign first_fault_channel = ff_ch_q;
  assign first_fault_high    = ff_high_q;

endmodule

// File: tb/tb_multichannel_comparator.sv
// Bench for multichannel_comparator: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the channel rules.
module tb_multichannel_comparator;
  localparam int N  = 4;
  localparam int DW = 16;

  logic                  clock;
  logic                  reset;
  logic signed [DW-1:0]  th [0:N-1][0:3];
  logic [7:0]            dbl;
  logic                  lmode;
  logic [N-1:0]          clr_latch;
  logic                  clr_ff;
  logic [N-1:0]          trip_high, trip_low;
  logic                  trip_any, ff_valid, ff_high;
  logic [1:0]            ff_ch;

  axi_stream #(.DATA_WIDTH(DW), .DEST_WIDTH(8)) s_if ();

  multichannel_comparator #(
    .DATA_PATH_WIDTH(DW),
    .N_CHANNELS     (N),
    .DEBOUNCE_WIDTH (8)
  ) u_dut (
    .clock              (clock),
    .reset              (reset),
    .thresholds         (th),
    .data_in            (s_if),
    .debounce_length    (dbl),
    .latching_mode      (lmode),
    .clear_latch        (clr_latch),
    .clear_first_fault  (clr_ff),
    .trip_high          (trip_high),
    .trip_low           (trip_low),
    .trip_any           (trip_any),
    .first_fault_valid  (ff_valid),
    .first_fault_channel(ff_ch),
    .first_fault_high   (ff_high)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state.
  int m_cnth [N];
  int m_cntl [N];
  bit m_trh  [N];
  bit m_trl  [N];
  bit m_lat  [N];
  bit m_ffv;
  int m_ffc;
  bit m_ffh;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnth[i] = 0; m_cntl[i] = 0; m_trh[i] = 0; m_trl[i] = 0; m_lat[i] = 0;
    end
    m_ffv = 0; m_ffc = 0; m_ffh = 0;
  endtask

  task automatic model_step();
    int c, dl, s;
    bit acc, sh, sl, hold, old_ffv;
    c   = int'(s_if.dest);
    acc = s_if.valid && (c < N);
    dl  = (dbl == 0) ? 1 : int'(dbl);
    s   = int'($signed(s_if.data));
    sh = 0; sl = 0; hold = 0;
    if (acc) begin
      hold = m_lat[c] && lmode;
      if (s > int'(th[c][3])) begin
        m_cnth[c] = (m_cnth[c] < 255) ? m_cnth[c] + 1 : 255;
        sh = (m_cnth[c] >= dl);
      end else m_cnth[c] = 0;
      if (s < int'(th[c][0])) begin
        m_cntl[c] = (m_cntl[c] < 255) ? m_cntl[c] + 1 : 255;
        sl = (m_cntl[c] >= dl);
      end else m_cntl[c] = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (!lmode) m_lat[i] = 0;
      else if (clr_latch[i]) begin
        m_lat[i] = 0; m_trh[i] = 0; m_trl[i] = 0;
      end
    end
    if (acc) begin
      if (s < int'(th[c][2]) && !hold) m_trh[c] = 0;
      if (s > int'(th[c][1]) && !hold) m_trl[c] = 0;
      if (sh) begin m_trh[c] = 1; m_lat[c] = lmode; end
      if (sl) begin m_trl[c] = 1; m_lat[c] = lmode; end
    end
    old_ffv = m_ffv;
    if (clr_ff) begin m_ffv = 0; m_ffc = 0; m_ffh = 0; end
    if ((sh || sl) && (!old_ffv || clr_ff)) begin
      m_ffv = 1; m_ffc = c; m_ffh = sh;
    end
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] eh, el;
    for (int i = 0; i < N; i++) begin eh[i] = m_trh[i]; el[i] = m_trl[i]; end
    check_eq({tag, ".trip_high"}, 32'(trip_high), 32'(eh));
    check_eq({tag, ".trip_low"},  32'(trip_low),  32'(el));
    check_eq({tag, ".trip_any"},  32'(trip_any),  32'((|eh) | (|el)));
    check_eq({tag, ".ff_valid"},  32'(ff_valid),  32'(m_ffv));
    check_eq({tag, ".ff_ch"},     32'(ff_ch),     32'(m_ffc));
    check_eq({tag, ".ff_high"},   32'(ff_high),   32'(m_ffh));
    check_eq({tag, ".ready"},     32'(s_if.ready), 32'd1);
  endtask

  // Inputs are driven 1 time unit after a rising edge; outputs checked at the same offset.
  task automatic cycle(input string tag);
    model_step();
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  task automatic send(input int ch, input int val, input string tag);
    s_if.valid = 1'b1;
    s_if.dest  = 8'(ch);
    s_if.data  = 16'(val);
    cycle(tag);
    s_if.valid     = 1'b0;
    clr_latch      = '0;
    clr_ff         = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #2;
    model_reset();
    check_all(tag);
    reset = 1'b1;
  endtask

  task automatic set_default_th();
    for (int c = 0; c < N; c++) begin
      th[c][0] = -16'sd100; th[c][1] = -16'sd80; th[c][2] = 16'sd80; th[c][3] = 16'sd100;
    end
  endtask

  initial begin
    reset = 1'b0; s_if.valid = 1'b0; s_if.data = '0; s_if.dest = '0;
    dbl = 8'd3; lmode = 1'b0; clr_latch = '0; clr_ff = 1'b0;
    set_default_th();
    model_reset();
    #12;
    check_all("reset");
    reset = 1'b1;
    @(posedge clock); #1;

    // Debounce of 3 on ch2.
    send(2, 150, "deb1"); send(2, 150, "deb2");
    check_eq("deb_not_yet", 32'(trip_high[2]), 32'd0);
    send(2, 150, "deb3");
    check_eq("deb_trip", 32'(trip_high[2]), 32'd1);
    check_eq("deb_ffch", 32'(ff_ch), 32'd2);
    check_eq("deb_ffhigh", 32'(ff_high), 32'd1);

    // Band sample restarts the count.
    do_reset("rst_band");
    send(2, 150, "band1"); send(2, 150, "band2"); send(2, 90, "band3");
    send(2, 150, "band4"); send(2, 150, "band5");
    check_eq("band_no_trip", 32'(trip_high[2]), 32'd0);
    send(2, 150, "band6");
    check_eq("band_trip", 32'(trip_high[2]), 32'd1);

    // Hysteresis without latching.
    do_reset("rst_hyst");
    dbl = 8'd1;
    send(0, 150, "hy1"); send(0, 90, "hy2");
    check_eq("hyst_hold", 32'(trip_high[0]), 32'd1);
    send(0, 70, "hy3");
    check_eq("hyst_release", 32'(trip_high[0]), 32'd0);
    check_eq("hyst_any", 32'(trip_any), 32'd0);

    // Latching, clear, and clear coincident with a new trip.
    lmode = 1'b1;
    send(1, -200, "lat1"); send(1, 0, "lat2");
    check_eq("latch_hold", 32'(trip_low[1]), 32'd1);
    clr_latch = 4'b0010; cycle("lat3"); clr_latch = '0;
    check_eq("latch_clear", 32'(trip_low[1]), 32'd0);
    clr_latch = 4'b0010; send(1, -200, "lat4");
    check_eq("latch_set_wins", 32'(trip_low[1]), 32'd1);
    lmode = 1'b0;
    send(1, 0, "lat5");
    check_eq("mode_off_release", 32'(trip_low[1]), 32'd0);

    // Out-of-range dest, then async reset mid-debounce.
    do_reset("rst_dest");
    send(5, 32767, "dest5");
    check_eq("dest_ignored", 32'(trip_any), 32'd0);
    dbl = 8'd3;
    send(0, 150, "pre0"); send(0, 150, "pre1"); send(0, 150, "pre2");
    send(2, 150, "mid1"); send(2, 150, "mid2");
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_clear", 32'(trip_any), 32'd0);
    model_reset();
    check_all("async");
    reset = 1'b1;
    send(2, 150, "mid3");
    check_eq("post_reset_no_trip", 32'(trip_high[2]), 32'd0);

    // First-fault retention and clear coincident with a new trip.
    do_reset("rst_ff");
    dbl = 8'd1;
    send(3, 150, "ff1"); send(0, -200, "ff2");
    check_eq("ff_retain_ch", 32'(ff_ch), 32'd3);
    send(0, 0, "ff3");
    clr_ff = 1'b1; send(0, -200, "ff4");
    check_eq("ff_new_ch", 32'(ff_ch), 32'd0);
    check_eq("ff_new_low", 32'(ff_high), 32'd0);
    check_eq("ff_new_valid", 32'(ff_valid), 32'd1);

    // Maximum debounce length.
    do_reset("rst_sat");
    dbl = 8'd255;
    for (int i = 0; i < 254; i++) send(1, 500, "sat");
    check_eq("sat_254", 32'(trip_high[1]), 32'd0);
    send(1, 500, "sat255");
    check_eq("sat_255", 32'(trip_high[1]), 32'd1);
    for (int i = 0; i < 5; i++) send(1, 500, "satx");

    // Randomized traffic.
    do_reset("rst_rand");
    for (int c = 0; c < N; c++) begin
      th[c][0] = 16'(-int'($urandom_range(70, 40)));
      th[c][1] = 16'(int'(th[c][0]) + int'($urandom_range(20, 0)));
      th[c][2] = 16'(int'($urandom_range(40, 10)));
      th[c][3] = 16'(int'(th[c][2]) + int'($urandom_range(20, 0)));
    end
    for (int i = 0; i < 3000; i++) begin
      s_if.valid = ($urandom_range(3, 0) != 0);
      s_if.dest  = 8'($urandom_range(5, 0));
      s_if.data  = 16'(int'($urandom_range(200, 0)) - 100);
      dbl        = 8'($urandom_range(3, 0));
      if ($urandom_range(63, 0) == 0) lmode = ~lmode;
      for (int b = 0; b < N; b++) clr_latch[b] = ($urandom_range(15, 0) == 0);
      clr_ff     = ($urandom_range(19, 0) == 0);
      cycle("rand");
    end
    s_if.valid = 1'b0; clr_latch = '0; clr_ff = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
